// File: rtl/ascii_hex_entry_pkg.sv
// Shared definitions for the hex line editor.
//   ASCII_BS / ASCII_ENTER / ASCII_ESC : control key codes
//   state_e                            : edit FSM encoding
//   hex_decode()                       : ASCII -> {is_hex, nibble}
package ascii_hex_entry_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

    // Returns {1'b1, value} for 0-9, A-F, a-f; all zeros for anything else.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, 4'(c - 8'h57)};
        end
        return r;
    endfunction

endpackage

// File: rtl/ascii_hex_entry_fifo.sv
// Generic synchronous FIFO (module sync_fifo), synchronous active-high reset.
//   push/din  : write side, ignored while full
//   pop/dout  : read side, ignored while empty; dout is the head (0 when empty)
//   full/empty/count : occupancy from registered state
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_comb begin
        full  = (cnt_q == CW'(DEPTH));
        empty = (cnt_q == '0);
        count = cnt_q;
        dout  = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/ascii_hex_entry.sv
// Hex line editor: turns ASCII key strobes into a DIGITS-nibble value,
// supports backspace / escape / enter, and queues committed values.
//   clk, rst            : clock, synchronous active-high reset
//   ascii_data/stb      : one-cycle character strobe
//   disp_num            : entry while editing, else last committed value
//   editing/digit_count : edit state and digits in entry
//   val_data/valid/ready: committed-value FIFO head with handshake
//   err_stb             : pulse on rejected digit or rejected commit
//
// state   | meaning
// ST_IDLE | no entry in progress, display shows last committed value
// ST_EDIT | at least one digit typed, display shows entry
module ascii_hex_entry
    import ascii_hex_entry_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEPTH    = 4,
    parameter int OVF_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   ascii_data,
    input  logic                         ascii_stb,
    output logic [4*DIGITS-1:0]          disp_num,
    output logic                         editing,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [4*DIGITS-1:0]          val_data,
    output logic                         val_valid,
    input  logic                         val_ready,
    output logic                         err_stb
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_e          state_q, state_d;
    logic [W-1:0]    entry_q, entry_d;
    logic [W-1:0]    last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            push;
    logic            fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] unused_fifo_count;
    logic [4:0]      dec;
    logic            is_hex;
    logic [3:0]      nib;
    logic            entry_full;

    always_comb begin
        dec        = hex_decode(ascii_data);
        is_hex     = dec[4];
        nib        = dec[3:0];
        entry_full = (cnt_q == CW'(DIGITS));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ascii_stb) begin
            case (state_q)
                ST_IDLE: if (is_hex) state_d = ST_EDIT;
                ST_EDIT: begin
                    if (!is_hex) begin
                        if (ascii_data == ASCII_BS && cnt_q == CW'(1)) state_d = ST_IDLE;
                        if (ascii_data == ASCII_ESC)                    state_d = ST_IDLE;
                        if (ascii_data == ASCII_ENTER && !fifo_full)   state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = 1'b0;
        push    = 1'b0;
        if (ascii_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_hex) begin
                        entry_d = W'(nib);
                        cnt_d   = CW'(1);
                    end
                end
                ST_EDIT: begin
                    if (is_hex) begin
                        if (!entry_full) begin
                            entry_d = (entry_q << 4) | W'(nib);
                            cnt_d   = cnt_q + CW'(1);
                        end else if (OVF_MODE != 0) begin
                            // Oldest digit falls off the top; count stays saturated.
                            entry_d = (entry_q << 4) | W'(nib);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (ascii_data == ASCII_BS) begin
                        entry_d = entry_q >> 4;
                        cnt_d   = cnt_q - CW'(1);
                    end else if (ascii_data == ASCII_ESC) begin
                        entry_d = '0;
                        cnt_d   = '0;
                    end else if (ascii_data == ASCII_ENTER) begin
                        // Full uses pre-edge occupancy; a same-cycle pop does not help.
                        if (!fifo_full) begin
                            push    = 1'b1;
                            last_d  = entry_q;
                            entry_d = '0;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        editing     = (state_q == ST_EDIT);
        disp_num    = editing ? entry_q : last_q;
        digit_count = cnt_q;
        err_stb     = err_q;
        val_valid   = !fifo_empty;
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry_q),
        .full  (fifo_full),
        .pop   (val_ready),
        .dout  (val_data),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

endmodule
